// File: rtl/fft_agu_ctrl_pkg.sv
// fft_agu_ctrl_pkg
// Shared constants for the FFT address-generation unit and its frame
// sequencer: AGU geometry, FSM state encodings, default frame timing and
// the phase-counter width.
// Ports: none (package).
package fft_agu_ctrl_pkg;

  // AGU geometry: 4096-point transform, four radix-8 stages.
  localparam int AGU_N_PTS    = 4096;
  localparam int AGU_N_STAGES = 4;
  localparam int AGU_ADDR_W   = 12;

  // Default frame timing. RUN covers every stage plus the datapath tail.
  localparam int PIPE_LAT_DEF = 48;
  localparam int LOAD_LEN_DEF = AGU_N_PTS;
  localparam int RUN_LEN_DEF  = AGU_N_STAGES * AGU_N_PTS + PIPE_LAT_DEF;

  localparam int CNT_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } fsm_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fft_phase_cnt.sv
// fft_phase_cnt
// Phase counter for the FFT frame sequencer. Counts up on inc, returns to
// zero on clr, and holds at CNT_MAX rather than wrapping.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   clr  - clear to zero (priority over inc)
//   inc  - advance by one
//   cnt  - current count
module fft_phase_cnt
  import fft_agu_ctrl_pkg::*;
#(
  parameter int CNT_MAX = RUN_LEN_DEF - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(CNT_MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fft_agu_ctrl.sv
// fft_agu_ctrl
// Frame sequencer for the FFT address-generation unit: loads one frame of
// samples, runs the AGU through every stage, drains the datapath, then
// pulses done.
// Optional feature: define FFT_CTRL_PERF_EN to add the stall_cnt output.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - frame request, honoured in IDLE only
//   abort           - drop the current frame, back to IDLE
//   in_valid        - load-sample valid
//   stall           - downstream back-pressure in RUN
//   AGU_en          - AGU count enable
//   rc_sel_out      - AGU load/reorder mode select
//   wrfd_en_out     - write-from-data enable
//   FFT_fin_wire    - final-output phase flag
//   busy, done      - frame in progress, one-cycle completion pulse
//   stall_cnt       - stalled RUN cycles this frame (FFT_CTRL_PERF_EN only)
//   state_out       - current state encoding
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | writing LOAD_LEN input samples
// RUN   | AGU counting through all stages, pauses on stall
// DRAIN | datapath flush, PIPE_LAT cycles
// DONE  | one-cycle completion
module fft_agu_ctrl
  import fft_agu_ctrl_pkg::*;
#(
  parameter int LOAD_LEN = LOAD_LEN_DEF,
  parameter int RUN_LEN  = RUN_LEN_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic        stall,
  output logic        AGU_en,
  output logic        rc_sel_out,
  output logic        wrfd_en_out,
  output logic        FFT_fin_wire,
  output logic        busy,
  output logic        done,
`ifdef FFT_CTRL_PERF_EN
  output logic [15:0] stall_cnt,
`endif
  output logic [2:0]  state_out
);

  localparam int CNT_MAX = max3(LOAD_LEN, RUN_LEN, PIPE_LAT) - 1;

  fsm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        if (abort) state_d = ST_IDLE;
        else if (in_valid && (cnt == CNT_W'(LOAD_LEN - 1))) state_d = ST_RUN;
        else state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (abort) state_d = ST_IDLE;
        else if (!stall && (cnt == CNT_W'(RUN_LEN - 1))) state_d = ST_DRAIN;
        else state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (abort) state_d = ST_IDLE;
        else if (cnt == CNT_W'(PIPE_LAT - 1)) state_d = ST_DONE;
        else state_d = ST_DRAIN;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every state change restarts the phase count, so each phase starts at 0.
  assign cnt_clr = (state_d != state_q);
  assign cnt_inc = ((state_q == ST_LOAD) && in_valid) ||
                   ((state_q == ST_RUN) && !stall) ||
                   (state_q == ST_DRAIN);

  fft_phase_cnt #(
    .CNT_MAX (CNT_MAX)
  ) u_phase_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  // Enables follow the handshake inputs combinationally; everything else
  // decodes from the registered state.
  always_comb begin
    AGU_en       = 1'b0;
    rc_sel_out   = 1'b0;
    wrfd_en_out  = 1'b0;
    FFT_fin_wire = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_LOAD: begin
        AGU_en      = in_valid;
        rc_sel_out  = in_valid;
        wrfd_en_out = in_valid;
        busy        = 1'b1;
      end
      ST_RUN: begin
        AGU_en = !stall;
        busy   = 1'b1;
      end
      ST_DRAIN: begin
        FFT_fin_wire = 1'b1;
        busy         = 1'b1;
      end
      ST_DONE: begin
        FFT_fin_wire = 1'b1;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;

`ifdef FFT_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_RUN) && stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// tb_fft_agu_ctrl
// Scoreboard bench for fft_agu_ctrl with default parameters. The stimulus
// side queues the expected state transitions (new state plus length of the
// state just left) and expected done latencies; the negedge monitor pops
// them whenever the DUT changes state or pulses done, and checks the output
// decode every cycle against the expected state.
module tb_fft_agu_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, stall;
  logic       AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy, done;
  logic [2:0] state_out;
`ifdef FFT_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fft_agu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .stall        (stall),
    .AGU_en       (AGU_en),
    .rc_sel_out   (rc_sel_out),
    .wrfd_en_out  (wrfd_en_out),
    .FFT_fin_wire (FFT_fin_wire),
    .busy         (busy),
    .done         (done),
`ifdef FFT_CTRL_PERF_EN
    .stall_cnt    (stall_cnt),
`endif
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    int         dur;  // cycles spent in the state being left; -1 = any
  } ev_t;

  ev_t  sb_q[$];
  int   start_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   exp_stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy, done}
  function automatic logic [5:0] exp_outs(input logic [2:0] st, input logic iv, input logic stl);
    case (st)
      3'd1:    return {iv, iv, iv, 1'b0, 1'b1, 1'b0};
      3'd2:    return {~stl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      3'd3:    return 6'b000110;
      3'd4:    return 6'b000101;
      default: return 6'b000000;
    endcase
  endfunction

  logic [2:0] prev_st = 3'd0;
  logic [2:0] exp_st  = 3'd0;
  int         seg_len = 0;

  always @(negedge clk) begin
    ev_t        ev;
    int         s;
    logic [5:0] eo, ao;
    if (mon_en) begin
      if (state_out != prev_st) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL transition: unexpected move %0d -> %0d at cycle %0d", prev_st, state_out, cyc);
        end else begin
          ev = sb_q.pop_front();
          exp_st = ev.st;
          if (ev.st != state_out || (ev.dur >= 0 && ev.dur != seg_len)) begin
            errors++;
            $display("FAIL transition: got state %0d after %0d cycles in %0d, want state %0d after %0d cycles",
                     state_out, seg_len, prev_st, ev.st, ev.dur);
          end
        end
`ifdef FFT_CTRL_PERF_EN
        if (state_out == 3'd3) begin
          checks++;
          if (stall_cnt != 16'(exp_stall_cnt)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall_cnt);
          end
        end
`endif
        prev_st = state_out;
        seg_len = 1;
      end else begin
        seg_len++;
      end

      eo = exp_outs(exp_st, in_valid, stall);
      ao = {AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy, done};
      checks++;
      if (ao !== eo) begin
        errors++;
        $display("FAIL outputs: cycle %0d state %0d got %b want %b", cyc, exp_st, ao, eo);
      end

      if (done === 1'b1) begin
        checks++;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL done_latency: unexpected done at cycle %0d", cyc);
        end else begin
          s = start_q.pop_front();
          // start cycle counts as cycle 1: 4096 LOAD + 16432 RUN + 48 DRAIN + 1 DONE + 1
          if (cyc - s + 1 != 20578) begin
            errors++;
            $display("FAIL done_latency: got %0d want 20578", cyc - s + 1);
          end
        end
      end

      if (errors >= 50) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [2:0] st, input int dur);
    ev_t e;
    e.st  = st;
    e.dur = dur;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    @(negedge clk);
    checks++;
    if ({state_out, AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy, done} !== 9'd0) begin
      errors++;
      $display("FAIL %s: got state %0d outs %b want state 0 outs 000000", name, state_out,
               {AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy, done});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; stall = 1'b0;
    tick();
    mon_en = 1'b1;
    start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    tick();
    check_all_zero("reset_state");
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    // Frame 1: continuous load, abort during RUN cycle 5000.
    push_ev(3'd1, -1);
    push_ev(3'd2, 4096);
    push_ev(3'd0, 5000);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (4096 + 4999) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    repeat (5) tick();

    // Frame 2: full frame, start pulses in RUN and in DONE are ignored.
    exp_stall_cnt = 0;
    push_ev(3'd1, -1);
    push_ev(3'd2, 4096);
    push_ev(3'd3, 16432);
    push_ev(3'd4, 48);
    push_ev(3'd0, 1);
    start_q.push_back(cyc);
    start = 1'b1; in_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (4096 + 99) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20576 - 4196) tick();
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    repeat (5) tick();

    // Frame 3: alternating in_valid, 100-cycle stall in RUN, reset in DRAIN.
    exp_stall_cnt = 100;
    push_ev(3'd1, -1);
    push_ev(3'd2, 8192);
    push_ev(3'd3, 16532);
    push_ev(3'd0, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      in_valid = i[0];
      tick();
    end
    in_valid = 1'b0;
    repeat (200) tick();
    stall = 1'b1;
    repeat (100) tick();
    stall = 1'b0;
    repeat (24724 - 8492) tick();
    stall = 1'b1;
    repeat (9) tick();
    rst = 1'b1; abort = 1'b1;
    tick();
    rst = 1'b0; abort = 1'b0; stall = 1'b0;
    check_all_zero("reset_in_drain");
`ifdef FFT_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_reset: got %0d want 0", stall_cnt);
    end
`endif
    repeat (5) tick();

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d transitions never seen, want 0", sb_q.size());
    end
    checks++;
    if (start_q.size() != 0) begin
      errors++;
      $display("FAIL done_seen: %0d done pulses missing, want 0", start_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_agu_ctrl.md
FFT_AGU_CTRL -- requirements
Module: fft_agu_ctrl

Interface
REQ-001 Parameter LOAD_LEN, default 4096: input samples per frame in LOAD.
REQ-002 Parameter RUN_LEN, default 16432: AGU-enabled cycles in RUN (4 stages x 4096, plus 48 tail).
REQ-003 Parameter PIPE_LAT, default 48: datapath drain cycles after RUN.
REQ-004 Port clk, input, 1: sole clock, rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: single-cycle frame request; sampled only in IDLE.
REQ-007 Port abort, input, 1: terminate the current frame.
REQ-008 Port in_valid, input, 1: load-sample valid.
REQ-009 Port stall, input, 1: downstream back-pressure during RUN.
REQ-010 Port AGU_en, output, 1: AGU count enable.
REQ-011 Port rc_sel_out, output, 1: AGU reorder/load mode select.
REQ-012 Port wrfd_en_out, output, 1: write-from-data enable.
REQ-013 Port FFT_fin_wire, output, 1: final-output phase flag to the AGU.
REQ-014 Port busy, output, 1: frame in progress.
REQ-015 Port done, output, 1: one-cycle frame-complete pulse.
REQ-016 Port state_out, output, 3: current state encoding.

Function
REQ-017 The FSM SHALL have the states IDLE=0, LOAD=1, RUN=2, DRAIN=3 and DONE=4; all other encodings SHALL go to IDLE on the next cycle.
REQ-018 In IDLE, start=1 SHALL move to LOAD on the next edge and clear the phase counter to 0.
REQ-019 In LOAD, rc_sel_out, wrfd_en_out and AGU_en SHALL equal in_valid combinationally, and the counter SHALL increment only when in_valid=1.
REQ-020 LOAD SHALL move to RUN on the edge where the counter equals LOAD_LEN-1 and in_valid=1, and the counter SHALL clear.
REQ-021 In RUN, AGU_en SHALL equal ~stall, rc_sel_out and wrfd_en_out SHALL be 0, and the counter SHALL advance only when stall=0.
REQ-022 RUN SHALL move to DRAIN on the edge where the counter equals RUN_LEN-1 and stall=0, and the counter SHALL clear.
REQ-023 In DRAIN, AGU_en SHALL be 0 and FFT_fin_wire SHALL be 1; the counter SHALL advance every cycle regardless of stall.
REQ-024 DRAIN SHALL move to DONE when the counter equals PIPE_LAT-1.
REQ-025 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE.
REQ-026 busy SHALL be 1 in LOAD, RUN and DRAIN, and 0 in IDLE and DONE.
REQ-027 FFT_fin_wire SHALL be 1 in DRAIN and DONE, and 0 in all other states.
REQ-028 All outputs other than the REQ-019/REQ-021 enables SHALL be registered or decoded from state only.
REQ-029 abort=1 in LOAD, RUN or DRAIN SHALL go to IDLE on the next edge, clear the counter, and not assert done; abort has priority over all transitions.
REQ-030 start received outside IDLE SHALL be ignored and not queued.
REQ-031 start=1 during the DONE cycle SHALL be ignored.
REQ-032 The phase counter SHALL be 15 bits, SHALL never exceed max(LOAD_LEN, RUN_LEN, PIPE_LAT)-1, and SHALL never wrap.

Reset
REQ-033 With rst=1 at a clock edge, the state SHALL become IDLE and the counter 0.
REQ-034 During and after reset, AGU_en, rc_sel_out, wrfd_en_out, FFT_fin_wire, busy and done SHALL all be 0, and state_out SHALL be 0.
REQ-035 rst SHALL override abort, start and every state transition, including in mid-frame.

Configuration
REQ-036 With macro FFT_CTRL_PERF_EN defined, the block SHALL add output stall_cnt[15:0], which counts RUN cycles with stall=1, clears on the IDLE-to-LOAD transition and saturates at 16'hFFFF.
REQ-037 Without FFT_CTRL_PERF_EN, the stall_cnt port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-038 The state encodings and the LOAD_LEN, RUN_LEN and PIPE_LAT defaults SHALL reside in the shared package/define file alongside the AGU constants.
REQ-039 The phase counter SHALL be implemented as sub-module fft_phase_cnt (inputs clr and inc; output cnt).
REQ-040 The FSM and output decode SHALL remain in fft_agu_ctrl.

Verification
REQ-041 rst, then start; drive in_valid=1 continuously -> 4096 LOAD cycles with rc_sel_out=1, then 16432 RUN cycles with AGU_en=1, then 48 DRAIN cycles; done asserts on cycle 20578 after start.
REQ-042 In LOAD, in_valid alternates 1/0 -> LOAD lasts 8192 cycles, and AGU_en toggles with in_valid.
REQ-043 In RUN, hold stall=1 for 100 cycles -> AGU_en=0 throughout and RUN is extended by exactly 100 cycles; with FFT_CTRL_PERF_EN, stall_cnt=100.
REQ-044 abort at RUN cycle 5000 -> IDLE next cycle, busy=0, no done pulse; a subsequent start runs a full frame.
REQ-045 start pulsed during RUN and during DONE -> ignored; exactly one done pulse occurs per frame.
REQ-046 rst asserted during DRAIN -> all outputs 0 the next cycle and state_out=0.
